// File: rtl/inst_sequencer.sv
// Multi-cycle instruction sequencer for the systolic-array datapath: accepts
// host instructions over valid/ready and replays them as bursts of buffer strobes.
module inst_sequencer #(
    parameter int OPCODE_BITS = 4,
    parameter int ADDRA_BITS  = 8,
    parameter int ADDRB_BITS  = 8,
    parameter int REP_BITS    = 4,
    parameter int RD_LAT      = 1,
    parameter int INST_BITS   = OPCODE_BITS + ADDRA_BITS + ADDRB_BITS + REP_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INST_BITS-1:0]  instruction,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic                  read_ub,
    output logic                  write_ub,
    output logic                  read_wb,
    output logic                  write_wb,
    output logic                  read_acc,
    output logic                  write_acc,
    output logic                  data_fifo_en,
    output logic                  weight_fifo_en,
    output logic                  mmu_load_weight_en,
    output logic                  mm_en,
    output logic                  acc_en,
    output logic                  ub_wdata_sel,
    output logic [ADDRA_BITS-1:0] addra,
    output logic [ADDRB_BITS-1:0] addrb
);

    typedef struct packed {
        logic [OPCODE_BITS-1:0] opcode;
        logic [ADDRA_BITS-1:0]  addra;
        logic [ADDRB_BITS-1:0]  addrb;
        logic [REP_BITS-1:0]    rep;
    } inst_t;

    typedef struct packed {
        logic read_ub;
        logic write_ub;
        logic read_wb;
        logic write_wb;
        logic read_acc;
        logic write_acc;
        logic data_fifo_en;
        logic weight_fifo_en;
        logic mmu_load_weight_en;
        logic mm_en;
        logic acc_en;
        logic ub_wdata_sel;
    } strb_t;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_RD, S_WAIT, S_WR} state_t;

    localparam logic [OPCODE_BITS-1:0] OP_IDLE         = OPCODE_BITS'(0);
    localparam logic [OPCODE_BITS-1:0] OP_DATA_FIFO    = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_WEIGHT_FIFO  = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_DATA   = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_WEIGHT = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_DATA    = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OP_LOAD_WEIGHT  = OPCODE_BITS'(6);
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL      = OPCODE_BITS'(7);
    localparam logic [OPCODE_BITS-1:0] OP_MAT_MUL_ACC  = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OP_WRITE_RESULT = OPCODE_BITS'(9);

    // S_WAIT lasts RD_LAT-1 cycles; the counter counts down to zero from here.
    localparam logic [3:0] WAIT_INIT = 4'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    inst_t                  inst_in;
    state_t                 state_q, state_d;
    logic [OPCODE_BITS-1:0] op_q;
    logic [ADDRA_BITS-1:0]  addra_q;
    logic [ADDRB_BITS-1:0]  addrb_q;
    logic [REP_BITS-1:0]    cnt_q;
    logic [3:0]             wait_q;
    logic                   done_q;
    logic                   illegal_q;

    logic  accept;
    logic  is_single;
    logic  is_two;
    logic  legal;
    logic  beat_end;
    logic  more;
    logic  finish;
    strb_t strb;

    assign inst_in    = instruction;
    assign inst_ready = (state_q == S_IDLE);
    assign busy       = ~inst_ready;
    assign accept     = inst_ready & inst_valid;

    assign is_single = inst_in.opcode inside {OP_DATA_FIFO, OP_WEIGHT_FIFO, OP_WRITE_DATA,
                                              OP_WRITE_WEIGHT, OP_MAT_MUL, OP_MAT_MUL_ACC};
    assign is_two    = inst_in.opcode inside {OP_LOAD_DATA, OP_LOAD_WEIGHT, OP_WRITE_RESULT};
    assign legal     = (inst_in.opcode == OP_IDLE) | is_single | is_two;

    always_comb begin
        state_d  = state_q;
        beat_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_single)   state_d = S_EXEC;
                    else if (is_two) state_d = S_RD;
                end
            end
            S_EXEC: beat_end = 1'b1;
            S_RD:   state_d = (RD_LAT == 1) ? S_WR : S_WAIT;
            S_WAIT: if (wait_q == 4'd0) state_d = S_WR;
            S_WR:   beat_end = 1'b1;
            default: state_d = S_IDLE;
        endcase

        more   = beat_end & (cnt_q != '0);
        finish = beat_end & (cnt_q == '0);
        if (beat_end)
            state_d = more ? ((state_q == S_EXEC) ? S_EXEC : S_RD) : S_IDLE;

        // Abort wins over a completing beat: no done, no address advance.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            more    = 1'b0;
            finish  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            addra_q   <= '0;
            addrb_q   <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= finish;
            illegal_q <= accept & ~legal;
            if (accept) begin
                op_q    <= inst_in.opcode;
                addra_q <= inst_in.addra;
                addrb_q <= inst_in.addrb;
                cnt_q   <= inst_in.rep;
            end else if (more) begin
                cnt_q   <= cnt_q - REP_BITS'(1);
                addra_q <= addra_q + ADDRA_BITS'(1);
                addrb_q <= addrb_q + ADDRB_BITS'(1);
            end
            if (state_q == S_RD)
                wait_q <= WAIT_INIT;
            else if (state_q == S_WAIT && wait_q != 4'd0)
                wait_q <= wait_q - 4'd1;
        end
    end

    // Strobes come from registered state only, never from the instruction port.
    always_comb begin
        strb = '0;
        case (state_q)
            S_EXEC: begin
                case (op_q)
                    OP_DATA_FIFO:    strb.data_fifo_en   = 1'b1;
                    OP_WEIGHT_FIFO:  strb.weight_fifo_en = 1'b1;
                    OP_WRITE_DATA:   strb.write_ub       = 1'b1;
                    OP_WRITE_WEIGHT: strb.write_wb       = 1'b1;
                    OP_MAT_MUL: begin
                        strb.mm_en     = 1'b1;
                        strb.write_acc = 1'b1;
                    end
                    OP_MAT_MUL_ACC: begin
                        strb.mm_en     = 1'b1;
                        strb.write_acc = 1'b1;
                        strb.acc_en    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_RD: begin
                case (op_q)
                    OP_LOAD_DATA:    strb.read_ub  = 1'b1;
                    OP_LOAD_WEIGHT:  strb.read_wb  = 1'b1;
                    OP_WRITE_RESULT: strb.read_acc = 1'b1;
                    default: ;
                endcase
            end
            S_WR: begin
                case (op_q)
                    OP_LOAD_DATA:    strb.data_fifo_en = 1'b1;
                    OP_LOAD_WEIGHT: begin
                        strb.mmu_load_weight_en = 1'b1;
                        strb.weight_fifo_en     = 1'b1;
                    end
                    OP_WRITE_RESULT: begin
                        strb.write_ub     = 1'b1;
                        strb.ub_wdata_sel = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign read_ub            = strb.read_ub;
    assign write_ub           = strb.write_ub;
    assign read_wb            = strb.read_wb;
    assign write_wb           = strb.write_wb;
    assign read_acc           = strb.read_acc;
    assign write_acc          = strb.write_acc;
    assign data_fifo_en       = strb.data_fifo_en;
    assign weight_fifo_en     = strb.weight_fifo_en;
    assign mmu_load_weight_en = strb.mmu_load_weight_en;
    assign mm_en              = strb.mm_en;
    assign acc_en             = strb.acc_en;
    assign ub_wdata_sel       = strb.ub_wdata_sel;
    assign done               = done_q;
    assign illegal            = illegal_q;
    assign addra              = addra_q;
    assign addrb              = addrb_q;

endmodule
